// File: rtl/serial_alu_ctrl.sv
// Bit-serial sequencer driving an external 1-bit ALU slice LSB first for WIDTH cycles.
// Optional: define SERIAL_ALU_OVERFLOW_EN to add a signed-overflow output for add/sub.
module serial_alu_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       control,
   output logic             ready,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic             alu_a,
   output logic             alu_b,
   output logic             alu_cin,
   output logic [2:0]       alu_control,
   input  logic             alu_out,
   input  logic             alu_cout
`ifdef SERIAL_ALU_OVERFLOW_EN
   ,
   output logic             overflow
`endif
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [2:0]       op;
   logic             carry;
   logic [CW-1:0]    cnt;

   // Operand bits and carry reach the slice only while running.
   assign alu_a       = (state == RUN) & a_sh[0];
   assign alu_b       = (state == RUN) & b_sh[0];
   assign alu_cin     = (state == RUN) & carry;
   assign alu_control = op;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         a_sh      <= '0;
         b_sh      <= '0;
         op        <= '0;
         carry     <= 1'b0;
         cnt       <= '0;
         result    <= '0;
         carry_out <= 1'b0;
         done      <= 1'b0;
         ready     <= 1'b1;
`ifdef SERIAL_ALU_OVERFLOW_EN
         overflow  <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  a_sh   <= a;
                  b_sh   <= b;
                  op     <= control;
                  cnt    <= '0;
                  result <= '0;
                  // Subtract is a + ~b + 1; the +1 enters as the initial carry.
                  carry  <= (control == 3'd3);
                  ready  <= 1'b0;
                  state  <= RUN;
`ifdef SERIAL_ALU_OVERFLOW_EN
                  overflow <= 1'b0;
`endif
               end
            end
            RUN: begin
               result <= {alu_out, result[WIDTH-1:1]};
               a_sh   <= a_sh >> 1;
               b_sh   <= b_sh >> 1;
               carry  <= alu_cout;
               cnt    <= cnt + CW'(1);
               if (cnt == CW'(WIDTH - 1)) begin
                  carry_out <= alu_cout;
                  done      <= 1'b1;
                  state     <= DONE;
`ifdef SERIAL_ALU_OVERFLOW_EN
                  // Carry into the MSB differs from carry out of it.
                  overflow  <= ((op == 3'd2) || (op == 3'd3)) & (carry ^ alu_cout);
`endif
               end
            end
            DONE: begin
               done  <= 1'b0;
               ready <= 1'b1;
               state <= IDLE;
            end
            default: begin
               done  <= 1'b0;
               ready <= 1'b1;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_alu_ctrl.sv
// Self-checking bench for serial_alu_ctrl with a behavioural 1-bit slice and arithmetic reference model.
module tb_serial_alu_ctrl;

   localparam int W = 8;

   logic         clock;
   logic         reset;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic [2:0]   control;
   logic         ready;
   logic         done;
   logic [W-1:0] result;
   logic         carry_out;
   logic         alu_a;
   logic         alu_b;
   logic         alu_cin;
   logic [2:0]   alu_control;
   logic         alu_out;
   logic         alu_cout;
`ifdef SERIAL_ALU_OVERFLOW_EN
   logic         overflow;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   serial_alu_ctrl #(.WIDTH(W)) dut (
      .clock       (clock),
      .reset       (reset),
      .start       (start),
      .a           (a),
      .b           (b),
      .control     (control),
      .ready       (ready),
      .done        (done),
      .result      (result),
      .carry_out   (carry_out),
      .alu_a       (alu_a),
      .alu_b       (alu_b),
      .alu_cin     (alu_cin),
      .alu_control (alu_control),
      .alu_out     (alu_out),
      .alu_cout    (alu_cout)
`ifdef SERIAL_ALU_OVERFLOW_EN
      ,
      .overflow    (overflow)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // 1-bit ALU slice: full adder with B inverted for subtract, plus bitwise ops.
   logic bb;
   always_comb begin
      bb       = (alu_control == 3'd3) ? ~alu_b : alu_b;
      alu_cout = (alu_a & bb) | (alu_a & alu_cin) | (bb & alu_cin);
      case (alu_control)
         3'd0:    alu_out = alu_a & alu_b;
         3'd1:    alu_out = alu_a | alu_b;
         3'd2,
         3'd3:    alu_out = alu_a ^ bb ^ alu_cin;
         3'd4:    alu_out = alu_a & alu_b;
         3'd5:    alu_out = alu_a | alu_b;
         3'd6:    alu_out = ~(alu_a | alu_b);
         default: alu_out = alu_a ^ alu_b;
      endcase
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Whole-word reference: returns {overflow, carry_out, result}.
   function automatic logic [W+1:0] ref_op(input logic [2:0] op, input logic [W-1:0] av,
                                            input logic [W-1:0] bv);
      logic [W:0]   s;
      logic [W-1:0] r;
      int           sa, sb, si;
      logic         ov;
      sa = int'($signed(av));
      sb = int'($signed(bv));
      s  = {1'b0, av} + {1'b0, bv};
      ov = 1'b0;
      case (op)
         3'd2: begin
            r  = s[W-1:0];
            si = sa + sb;
            ov = (si > (2**(W-1)) - 1) || (si < -(2**(W-1)));
         end
         3'd3: begin
            s  = {1'b0, av} + {1'b0, ~bv} + (W+1)'(1);
            r  = s[W-1:0];
            si = sa - sb;
            ov = (si > (2**(W-1)) - 1) || (si < -(2**(W-1)));
         end
         3'd4:    r = av & bv;
         3'd5:    r = av | bv;
         3'd6:    r = ~(av | bv);
         default: r = av ^ bv;
      endcase
      return {ov, s[W], r};
   endfunction

   // Issue one operation, scramble the inputs after acceptance, check latency and results.
   task automatic do_op(input string name, input logic [2:0] op, input logic [W-1:0] av,
                        input logic [W-1:0] bv, input logic [W-1:0] er, input logic ec,
                        input logic eo);
      int lat;
      @(negedge clock);
      start = 1'b1; a = av; b = bv; control = op;
      @(posedge clock);
      #1;
      start = 1'b0; a = W'($urandom); b = W'($urandom); control = 3'($urandom);
      lat = 0;
      do begin
         @(negedge clock);
         lat++;
      end while (!done && lat < 40);
      check({name, " latency"}, lat, W + 1);
      check({name, " result"}, result, er);
      check({name, " carry_out"}, carry_out, ec);
      check({name, " ready_in_done"}, ready, 0);
`ifdef SERIAL_ALU_OVERFLOW_EN
      check({name, " overflow"}, overflow, eo);
`else
      if (eo === 1'bx) check({name, " eo"}, eo, 0);
`endif
      @(negedge clock);
      check({name, " ready_after"}, ready, 1);
      check({name, " done_pulse"}, done, 0);
      check({name, " result_hold"}, result, er);
   endtask

   typedef struct {
      logic [2:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] res;
      logic         co;
      logic         ov;
   } vec_t;

   vec_t vecs[7];

   initial begin
      logic [W+1:0] exp;
      logic [2:0]   rop;
      logic [W-1:0] ra, rb;
      int           ready_bad, done_cyc, done_seen, n;

      vecs[0] = '{3'd2, 8'h5A, 8'h27, 8'h81, 1'b0, 1'b1};
      vecs[1] = '{3'd2, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
      vecs[2] = '{3'd2, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
      vecs[3] = '{3'd3, 8'h10, 8'h01, 8'h0F, 1'b1, 1'b0};
      vecs[4] = '{3'd3, 8'h01, 8'h02, 8'hFF, 1'b0, 1'b0};
      vecs[5] = '{3'd7, 8'hF0, 8'h3C, 8'hCC, 1'b1, 1'b0};
      vecs[6] = '{3'd4, 8'hF0, 8'h3C, 8'h30, 1'b1, 1'b0};

      reset = 1'b1; start = 1'b0; a = '0; b = '0; control = '0;
      repeat (2) @(negedge clock);
      check("rst ready", ready, 1);
      check("rst done", done, 0);
      check("rst result", result, 0);
      check("rst carry_out", carry_out, 0);
      check("rst alu_bits", {alu_a, alu_b, alu_cin}, 0);
      check("rst alu_control", alu_control, 0);
      reset = 1'b0;

      for (int i = 0; i < 7; i++)
         do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
               vecs[i].res, vecs[i].co, vecs[i].ov);

      // Start held from cycle 3 through DONE: ignored until back in IDLE.
      @(negedge clock);
      start = 1'b1; a = 8'h5A; b = 8'h27; control = 3'd2;
      @(posedge clock);
      #1 start = 1'b0;
      ready_bad = 0; done_cyc = 0;
      for (int c = 1; c <= 11; c++) begin
         @(negedge clock);
         if (c == 3) begin
            start = 1'b1; a = 8'h01; b = 8'h02; control = 3'd3;
         end
         if (c <= 9 && ready) ready_bad = 1;
         if (done && done_cyc == 0) done_cyc = c;
         if (c == 10) begin
            check("midop ready_c10", ready, 1);
            check("midop result", result, 8'h81);
            check("midop carry_out", carry_out, 0);
         end
         if (c == 11) begin
            check("restart accepted", ready, 0);
            start = 1'b0;
         end
      end
      check("midop ready_low", ready_bad, 0);
      check("midop done_cycle", done_cyc, 9);
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (!done && n < 40);
      check("restart done_seen", done, 1);
      check("restart result", result, 8'hFF);
      check("restart carry_out", carry_out, 0);
      @(negedge clock);

      // Reset during a run.
      @(negedge clock);
      start = 1'b1; a = 8'hFF; b = 8'hFF; control = 3'd2;
      @(posedge clock);
      #1 start = 1'b0;
      repeat (4) @(negedge clock);
      reset = 1'b1;
      #1;
      check("midrst result", result, 0);
      check("midrst ready", ready, 1);
      check("midrst done", done, 0);
      check("midrst alu_control", alu_control, 0);
      check("midrst alu_bits", {alu_a, alu_b, alu_cin}, 0);
      @(negedge clock);
      reset = 1'b0;
      done_seen = 0;
      repeat (12) begin
         @(negedge clock);
         if (done) done_seen = 1;
      end
      check("midrst no_done", done_seen, 0);
      check("midrst result_after", result, 0);
      do_op("post_rst add", 3'd2, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0);

      // Randomized operations against the whole-word reference.
      for (int i = 0; i < 30; i++) begin
         rop = 3'($urandom_range(2, 7));
         ra  = W'($urandom);
         rb  = W'($urandom);
         exp = ref_op(rop, ra, rb);
         do_op($sformatf("rnd%0d op%0d %0h,%0h", i, rop, ra, rb), rop, ra, rb,
               exp[W-1:0], exp[W], exp[W+1]);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/serial_alu_ctrl.md
Name: serial_alu_ctrl

Overview:
- Bit-serial sequencer that computes a WIDTH-bit ALU operation by driving one external 1-bit ALU slice for WIDTH cycles, LSB first.
- Latches operands and opcode on start, feeds one bit pair per cycle, chains the carry through an internal register, and assembles the result in a shift register.
- Lets datapaths that need only occasional wide arithmetic share a single 1-bit slice.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
- clock  input  1  system clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-high; clears all state
- start  input  1  request; sampled only while ready=1
- a  input  WIDTH  operand A, sampled with start
- b  input  WIDTH  operand B, sampled with start
- control  input  3  ALU opcode, sampled with start: 2=add, 3=sub, 4=and, 5=or, 6=nor, 7=xor
- ready  output  1  high in IDLE
- done  output  1  one-cycle pulse when result is final
- result  output  WIDTH  assembled result; holds until the next accepted start
- carry_out  output  1  final slice cout of the last completed operation
- alu_a  output  1  bit to slice A
- alu_b  output  1  bit to slice B
- alu_cin  output  1  slice carry-in
- alu_control  output  3  slice opcode
- alu_out  input  1  slice result bit (combinational from alu_* outputs)
- alu_cout  input  1  slice carry-out

Behaviour:
- Reset values:
  - State is IDLE.
  - result=0, carry_out=0, done=0, ready=1.
  - alu_a=0, alu_b=0, alu_cin=0, alu_control=0.
  - Shift registers, carry register and counter are 0.
- States:
  - IDLE: start=1 at an edge -> RUN. On that edge: a_sh<=a, b_sh<=b, op<=control, cnt<=0, result<=0, carry<=(control==3). The sub carry-in of 1 supplies the two's-complement +1.
  - RUN: alu_a=a_sh[0], alu_b=b_sh[0], alu_cin=carry, alu_control=op. Each edge:
    - result <= {alu_out, result[WIDTH-1:1]}
    - a_sh and b_sh shift right
    - carry <= alu_cout
    - cnt <= cnt+1
  - RUN exit: on the edge where cnt==WIDTH-1, carry_out<=alu_cout and state -> DONE.
  - DONE: done=1 for exactly one cycle, then IDLE on the next edge.
- Outputs by state:
  - ready=1 only in IDLE.
  - alu_a, alu_b and alu_cin are 0 outside RUN.
  - alu_control = op in all states.
- Latency:
  - start sampled at edge 0.
  - RUN occupies cycles 1..WIDTH.
  - done is high during cycle WIDTH+1.
  - ready is high again at cycle WIDTH+2.
  - Throughput is one operation per WIDTH+2 cycles.
- Logic ops (4..7): carry is still captured, and carry_out reflects the slice's cout for the MSB. Consumers ignore it for these ops.
- Opcodes 0 and 1 are passed to the slice unchanged; the controller does not check them.
- Boundary conditions:
  - start while in RUN or DONE is ignored; the inputs are not re-latched.
  - start in the same cycle that done is high is ignored; it is only accepted once back in IDLE.
  - Changes on a, b or control after acceptance have no effect.
  - reset asserted mid-RUN: immediate return to reset values; a partial result is never visible after reset.
  - Counter width is $clog2(WIDTH+1).

Optional Feature:
- Macro: SERIAL_ALU_OVERFLOW_EN.
- Defined:
  - Extra output port overflow (1 bit).
  - On the final RUN edge: overflow <= carry XOR alu_cout, i.e. carry into the MSB XOR carry out of the MSB, for op 2 or 3; 0 for all other ops.
  - overflow resets to 0 and holds like result.
- Not defined: the port and its logic are absent; everything else is identical.

Test Plan:
- WIDTH=8, control=2, a=8'h5A, b=8'h27, start pulse -> done at cycle 9; result=8'h81, carry_out=0.
- control=2, a=8'hFF, b=8'h01 -> result=8'h00, carry_out=1; with SERIAL_ALU_OVERFLOW_EN, a=8'h7F, b=8'h01 -> result=8'h80, overflow=1.
- control=3, a=8'h10, b=8'h01 -> result=8'h0F, carry_out=1; control=3, a=8'h01, b=8'h02 -> result=8'hFF, carry_out=0.
- control=7, a=8'hF0, b=8'h3C -> result=8'hCC. Then control=4 on the same operands -> 8'h30.
- Mid-op start with new operands at cycle 3 -> ignored; the original result is produced and ready stays 0 until cycle 10.
- reset pulsed at cycle 4 of a run -> result=0, ready=1, done never pulses; a following add 8'h01+8'h01 -> 8'h02.
